// File: rtl/lab71soc_timer_pkg.sv
// ---------------------------------------------------------------------------
// lab71soc_timer_pkg
// Shared definitions for the interval-timer controller: register map of the
// 16-bit interval timer slave, control register bit positions, the controller
// FSM state encoding and a helper that derives the period register value.
// ---------------------------------------------------------------------------
package lab71soc_timer_pkg;

  // Interval timer register map (word addresses)
  localparam logic [3:0] TMR_STATUS  = 4'd0;
  localparam logic [3:0] TMR_CONTROL = 4'd1;
  localparam logic [3:0] TMR_PERIOD0 = 4'd2;
  localparam logic [3:0] TMR_PERIOD1 = 4'd3;
  localparam logic [3:0] TMR_PERIOD2 = 4'd4;
  localparam logic [3:0] TMR_PERIOD3 = 4'd5;
  localparam logic [3:0] TMR_SNAP0   = 4'd6;
  localparam logic [3:0] TMR_SNAP1   = 4'd7;
  localparam logic [3:0] TMR_SNAP2   = 4'd8;
  localparam logic [3:0] TMR_SNAP3   = 4'd9;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_P0   = 4'd1,
    S_WR_P1   = 4'd2,
    S_WR_P2   = 4'd3,
    S_WR_P3   = 4'd4,
    S_WR_CTRL = 4'd5,
    S_RUN     = 4'd6,
    S_ACK     = 4'd7,
    S_STOP    = 4'd8
  } timer_state_e;

  // The timer counts load..0, so a period of N cycles loads N-1. Periods of
  // 0 and 1 are clamped so the timer never gets a zero load.
  function automatic logic [31:0] calc_load(input logic [31:0] period);
    if (period < 32'd2) begin
      return 32'd1;
    end else begin
      return period - 32'd1;
    end
  endfunction

endpackage

// File: rtl/lab71soc_timer_ctrl.sv
// ---------------------------------------------------------------------------
// lab71soc_timer_ctrl
// Programs an interval timer over a write-only 16-bit register bus, then
// acknowledges its timeouts and turns each one into a single-cycle tick.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cfg_valid/cfg_ready     configuration handshake (ready only in IDLE)
//   cfg_period[31:0]        tick period in clk cycles
//   cfg_continuous          1 = periodic, 0 = one-shot
//   stop_req                single-cycle stop request
//   tmr_address/chipselect/write_n/writedata   write master to the timer
//   tmr_irq                 timer timeout interrupt
//   tick, tick_count        tick pulse and running tick counter
//   running, busy           status
//
// Build option
//   TIMER_CTRL_TICK_COUNT_EN  when defined, tick_count counts ticks;
//                             otherwise it is tied to zero.
//
// All bus/status outputs are registered decodes of the current state, so the
// bus write for a state appears in the cycle after that state is entered.
// cfg_ready and busy are registered from the next state so they stay aligned
// with the state that actually accepts configuration.
// ---------------------------------------------------------------------------
module lab71soc_timer_ctrl
  import lab71soc_timer_pkg::*;
#(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              stop_req,
  output logic [3:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              running,
  output logic              busy
);

  timer_state_e state_r;
  timer_state_e next_state_s;
  logic [31:0]  load_r;
  logic         cont_r;
  logic         stop_pend_r;
  logic         irq_armed_r;
  logic         stop_now_s;
  logic         wr_en_s;
  logic [3:0]   wr_addr_s;
  logic [15:0]  wr_data_s;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic and per-state bus write decode
  always_comb begin
    next_state_s = state_r;
    wr_en_s      = 1'b0;
    wr_addr_s    = 4'd0;
    wr_data_s    = 16'd0;
    stop_now_s   = stop_pend_r | stop_req;
    case (state_r)
      S_IDLE: begin
        if (cfg_valid) begin
          next_state_s = S_WR_P0;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WR_P0: begin
        wr_en_s      = 1'b1;
        wr_addr_s    = TMR_PERIOD0;
        wr_data_s    = load_r[15:0];
        next_state_s = S_WR_P1;
      end
      S_WR_P1: begin
        wr_en_s      = 1'b1;
        wr_addr_s    = TMR_PERIOD1;
        wr_data_s    = load_r[31:16];
        next_state_s = S_WR_P2;
      end
      S_WR_P2: begin
        wr_en_s      = 1'b1;
        wr_addr_s    = TMR_PERIOD2;
        next_state_s = S_WR_P3;
      end
      S_WR_P3: begin
        wr_en_s      = 1'b1;
        wr_addr_s    = TMR_PERIOD3;
        next_state_s = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        wr_en_s                = 1'b1;
        wr_addr_s              = TMR_CONTROL;
        wr_data_s[CTRL_ITO]    = 1'b1;
        wr_data_s[CTRL_START]  = 1'b1;
        wr_data_s[CTRL_CONT]   = cont_r;
        next_state_s           = S_RUN;
      end
      S_RUN: begin
        // A timeout wins over a simultaneous stop; the stop stays latched
        // and is honoured on the way out of ACK.
        if (tmr_irq && irq_armed_r) begin
          next_state_s = S_ACK;
        end else if (stop_now_s) begin
          next_state_s = S_STOP;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_ACK: begin
        wr_en_s   = 1'b1;
        wr_addr_s = TMR_STATUS;
        if (stop_now_s) begin
          next_state_s = S_STOP;
        end else if (!cont_r) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_STOP: begin
        wr_en_s              = 1'b1;
        wr_addr_s            = TMR_CONTROL;
        wr_data_s[CTRL_STOP] = 1'b1;
        next_state_s         = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Configuration capture, stop latch and irq re-arm tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_r      <= 32'd1;
      cont_r      <= 1'b0;
      stop_pend_r <= 1'b0;
      irq_armed_r <= 1'b1;
    end else begin
      if (state_r == S_IDLE && cfg_valid) begin
        load_r <= calc_load(cfg_period);
        cont_r <= cfg_continuous;
      end else begin
        load_r <= load_r;
        cont_r <= cont_r;
      end
      if (next_state_s == S_IDLE) begin
        stop_pend_r <= 1'b0;
      end else if (stop_req && state_r != S_IDLE) begin
        stop_pend_r <= 1'b1;
      end else begin
        stop_pend_r <= stop_pend_r;
      end
      // The irq stays high until the status clear reaches the timer, so one
      // timeout may be seen for several cycles; only a low level re-arms.
      if (state_r == S_RUN && tmr_irq && irq_armed_r) begin
        irq_armed_r <= 1'b0;
      end else if (!tmr_irq) begin
        irq_armed_r <= 1'b1;
      end else begin
        irq_armed_r <= irq_armed_r;
      end
    end
  end

  // Registered bus and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 4'd0;
      tmr_writedata  <= 16'd0;
      tick           <= 1'b0;
      running        <= 1'b0;
      cfg_ready      <= 1'b1;
      busy           <= 1'b0;
    end else begin
      tmr_chipselect <= wr_en_s;
      tmr_write_n    <= ~wr_en_s;
      tmr_address    <= wr_addr_s;
      tmr_writedata  <= wr_data_s;
      tick           <= (state_r == S_ACK);
      running        <= (state_r == S_RUN) || (state_r == S_ACK) || (state_r == S_STOP);
      cfg_ready      <= (next_state_s == S_IDLE);
      busy           <= (next_state_s != S_IDLE);
    end
  end

`ifdef TIMER_CTRL_TICK_COUNT_EN
  logic [TICK_W-1:0] tick_count_r;

  // Tick counter, advances in step with the tick pulse and wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count_r <= {TICK_W{1'b0}};
    end else if (state_r == S_ACK) begin
      tick_count_r <= tick_count_r + {{(TICK_W-1){1'b0}}, 1'b1};
    end else begin
      tick_count_r <= tick_count_r;
    end
  end

  assign tick_count = tick_count_r;
`else
  assign tick_count = {TICK_W{1'b0}};
`endif

endmodule

// File: tb/tb_lab71soc_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lab71soc_timer_ctrl
// Directed bench for the interval-timer controller. With
// TIMER_CTRL_TICK_COUNT_EN defined the DUT is built with a 3-bit counter so
// the all-ones wrap is reached after a handful of ticks.
// ---------------------------------------------------------------------------
module tb_lab71soc_timer_ctrl;

`ifdef TIMER_CTRL_TICK_COUNT_EN
  localparam int TB_TICK_W = 3;
`else
  localparam int TB_TICK_W = 16;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [31:0]          cfg_period;
  logic                 cfg_continuous;
  logic                 stop_req;
  logic [3:0]           tmr_address;
  logic                 tmr_chipselect;
  logic                 tmr_write_n;
  logic [15:0]          tmr_writedata;
  logic                 tmr_irq;
  logic                 tick;
  logic [TB_TICK_W-1:0] tick_count;
  logic                 running;
  logic                 busy;

  int err_cnt = 0;
  int chk_cnt = 0;
  int exp_ticks = 0;

  lab71soc_timer_ctrl #(.TICK_W(TB_TICK_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_period     (cfg_period),
    .cfg_continuous (cfg_continuous),
    .stop_req       (stop_req),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq),
    .tick           (tick),
    .tick_count     (tick_count),
    .running        (running),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_count();
`ifdef TIMER_CTRL_TICK_COUNT_EN
    return 32'(exp_ticks % (1 << TB_TICK_W));
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_bus_idle(input string tag);
    check({tag, "_cs"}, {31'd0, tmr_chipselect}, 32'd0);
    check({tag, "_wn"}, {31'd0, tmr_write_n}, 32'd1);
    check({tag, "_ad"}, {28'd0, tmr_address}, 32'd0);
    check({tag, "_wd"}, {16'd0, tmr_writedata}, 32'd0);
  endtask

  task automatic check_write(input string tag, input logic [3:0] a, input logic [15:0] d);
    check({tag, "_cswn"}, {30'd0, tmr_chipselect, tmr_write_n}, 32'd2);
    check({tag, "_ad"}, {28'd0, tmr_address}, {28'd0, a});
    check({tag, "_wd"}, {16'd0, tmr_writedata}, {16'd0, d});
  endtask

  // Handshake, then the five programming writes, then running.
  task automatic start_cfg(input logic [31:0] period, input logic cont,
                           input logic [15:0] lo, input logic [15:0] hi,
                           input logic [15:0] ctrl);
    logic [3:0]  ea [5];
    logic [15:0] ed [5];
    ea = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    ed = '{lo, hi, 16'd0, 16'd0, ctrl};
    cfg_valid      = 1'b1;
    cfg_period     = period;
    cfg_continuous = cont;
    check("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    step();
    cfg_valid = 1'b0;
    check("cfg_ready_busy", {31'd0, cfg_ready}, 32'd0);
    check("busy_cfg", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("prog_wr%0d", i), {16'd0, tmr_writedata}, {16'd0, ed[i]});
      check($sformatf("prog_ad%0d", i), {27'd0, tmr_chipselect, tmr_address},
            {27'd0, 1'b1, ea[i]});
      check($sformatf("prog_run%0d", i), {31'd0, running}, 32'd0);
    end
    step();
    check("running_on", {31'd0, running}, 32'd1);
    check("bus_quiet_run", {31'd0, tmr_chipselect}, 32'd0);
  endtask

  // One-cycle irq in continuous RUN; expects a status clear and a tick.
  task automatic pulse_irq(input string tag);
    tmr_irq = 1'b1;
    step();
    tmr_irq = 1'b0;
    check({tag, "_tick_early"}, {31'd0, tick}, 32'd0);
    step();
    check_write({tag, "_ack"}, 4'd0, 16'h0000);
    check({tag, "_tick"}, {31'd0, tick}, 32'd1);
    exp_ticks++;
    check({tag, "_cnt"}, {{(32-TB_TICK_W){1'b0}}, tick_count}, exp_count());
  endtask

  task automatic stop_run(input string tag);
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    step();
    check_write({tag, "_stop"}, 4'd1, 16'h0008);
    check({tag, "_ready"}, {31'd0, cfg_ready}, 32'd1);
    step();
    check({tag, "_run_off"}, {31'd0, running}, 32'd0);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n_wr;
    int n_tk;
    reset_n        = 1'b1;
    cfg_valid      = 1'b0;
    cfg_period     = 32'd0;
    cfg_continuous = 1'b0;
    stop_req       = 1'b0;
    tmr_irq        = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check_bus_idle("rst");
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_run", {30'd0, running, tick}, 32'd0);
    check("rst_cnt", {{(32-TB_TICK_W){1'b0}}, tick_count}, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    step();

    // Continuous, period 50000 -> load 49999 = 0xC34F
    start_cfg(32'd50000, 1'b1, 16'hC34F, 16'h0000, 16'h0007);

    // irq held high for three cycles -> a single acknowledge and tick
    tmr_irq = 1'b1;
    n_wr = 0;
    n_tk = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) tmr_irq = 1'b0;
      step();
      if (tmr_chipselect && tmr_address == 4'd0) n_wr++;
      if (tick) n_tk++;
    end
    exp_ticks++;
    check("irq3_acks", n_wr, 32'd1);
    check("irq3_ticks", n_tk, 32'd1);
    check("irq3_cnt", {{(32-TB_TICK_W){1'b0}}, tick_count}, exp_count());

    // Run of ticks: wraps the counter when it is built, stays 0 otherwise
    for (int i = 0; i < 9; i++) begin
      pulse_irq($sformatf("t%0d", i));
    end
    stop_run("s1");

    // One-shot, period 1 -> load 1; one irq returns to IDLE
    start_cfg(32'd1, 1'b0, 16'h0001, 16'h0000, 16'h0005);
    tmr_irq = 1'b1;
    step();
    tmr_irq = 1'b0;
    step();
    check_write("os_ack", 4'd0, 16'h0000);
    check("os_tick", {31'd0, tick}, 32'd1);
    check("os_ready", {31'd0, cfg_ready}, 32'd1);
    check("os_busy", {31'd0, busy}, 32'd0);
    exp_ticks++;
    step();
    check("os_run_off", {31'd0, running}, 32'd0);
    check_bus_idle("os_after");

    // Period 0 also loads 1; then irq and stop in the same RUN cycle
    start_cfg(32'd0, 1'b1, 16'h0001, 16'h0000, 16'h0007);
    tmr_irq  = 1'b1;
    stop_req = 1'b1;
    step();
    tmr_irq  = 1'b0;
    stop_req = 1'b0;
    step();
    check_write("co_ack", 4'd0, 16'h0000);
    check("co_tick", {31'd0, tick}, 32'd1);
    exp_ticks++;
    step();
    check_write("co_stop", 4'd1, 16'h0008);
    check("co_tick_off", {31'd0, tick}, 32'd0);
    step();
    check_bus_idle("co_idle");
    check("co_ready", {31'd0, cfg_ready}, 32'd1);
    check("co_run_off", {31'd0, running}, 32'd0);
    check("co_cnt", {{(32-TB_TICK_W){1'b0}}, tick_count}, exp_count());

    // stop_req in IDLE is dropped: the next run keeps running
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    start_cfg(32'h0001_0002, 1'b1, 16'h0001, 16'h0001, 16'h0007);
    n_wr = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tmr_chipselect) n_wr++;
    end
    check("idle_stop_ignored_wr", n_wr, 32'd0);
    check("idle_stop_ignored_run", {31'd0, running}, 32'd1);
    stop_run("s2");

    // Reset while the FSM sits in WR_P2
    cfg_valid      = 1'b1;
    cfg_period     = 32'd50000;
    cfg_continuous = 1'b1;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    check_write("pre_rst_p1", 4'd3, 16'h0000);
    #2 reset_n = 1'b0;
    #1;
    check_bus_idle("mid_rst");
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("mid_rst_busy", {30'd0, busy, running}, 32'd0);
    check("mid_rst_cnt", {{(32-TB_TICK_W){1'b0}}, tick_count}, 32'd0);
    exp_ticks = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tmr_chipselect || !tmr_write_n) n_wr++;
    end
    check("post_rst_no_wr", n_wr, 32'd0);
    check("post_rst_ready", {31'd0, cfg_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
